// File: rtl/frame_sequencer.sv
// frame_sequencer: front-end controller for the processing chain.
// Sends a host-requested number of fixed-length frames as o_dv bursts.
// Each frame is gated by i_ready. The sequencer waits for the chain to
// acknowledge a frame before it sends the next one, and leaves a fixed
// idle gap between frames.
module frame_sequencer #(
  parameter int FRAME_LEN = 16,
  parameter int GAP       = 2,
  parameter int NBF_W     = 8,
  localparam int SCW      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NBF_W-1:0] i_nb_frames,
  input  logic             i_abort,
  input  logic             i_ready,
  input  logic             i_frame_done,
  output logic             o_dv,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBF_W-1:0] o_frame_cnt,
  output logic [SCW-1:0]   o_sample_cnt
);

  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(FRAME_LEN - 1);
  localparam logic [GCW-1:0] LAST_GAP    = GCW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NBF_W-1:0] nb;
  logic [GCW-1:0]   gap_cnt;
  logic [NBF_W-1:0] frame_cnt_inc;
  logic             abort_hit;

  // Abort only matters once a run is active; in IDLE it has no effect.
  assign abort_hit     = i_abort && (state != S_IDLE);
  assign frame_cnt_inc = o_frame_cnt + NBF_W'(1);

  // The sample handshake is combinational so that a stalled chain never sees a valid.
  assign o_dv  = (state == S_SEND) && i_ready;
  assign o_sof = o_dv && (o_sample_cnt == '0);
  assign o_eof = o_dv && (o_sample_cnt == LAST_SAMPLE);

  // State register plus the registered status flags derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_next;
      o_busy <= (state_next != S_IDLE);
      o_done <= (state_next == S_FINISH);
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_next = (i_nb_frames == '0) ? S_FINISH : S_SEND;
        end
      end
      S_SEND: begin
        if (o_eof) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_frame_done) begin
          if (frame_cnt_inc == nb) begin
            state_next = S_FINISH;
          end else if (GAP == 0) begin
            state_next = S_SEND;
          end else begin
            state_next = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == LAST_GAP) begin
          state_next = S_SEND;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (abort_hit) begin
      state_next = S_IDLE;
    end
  end

  // Run bookkeeping: latched frame request, frame/sample/gap counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      nb           <= '0;
      o_frame_cnt  <= '0;
      o_sample_cnt <= '0;
      gap_cnt      <= '0;
    end else if (!abort_hit) begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            nb           <= i_nb_frames;
            o_frame_cnt  <= '0;
            o_sample_cnt <= '0;
          end
        end
        S_SEND: begin
          if (o_dv) begin
            o_sample_cnt <= o_eof ? '0 : o_sample_cnt + SCW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (i_frame_done) begin
            o_frame_cnt <= frame_cnt_inc;
            gap_cnt     <= '0;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + GCW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
